// File: rtl/semaforo_pkg.sv
// Shared phase encoding and lamp colour constants for the semaforo_multi intersection controller.
package semaforo_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

  localparam logic [2:0] C_GREEN  = 3'b001;
  localparam logic [2:0] C_YELLOW = 3'b010;
  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_DARK   = 3'b000;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/semaforo_rr_pick.sv
// Combinational round-robin picker: nearest requesting approach after i_cur, else i_cur+1.
module semaforo_rr_pick
  import semaforo_pkg::*;
#(
  parameter  int unsigned N_WAY = 2,
  localparam int unsigned IDX_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-1:0] i_req_q,
  input  logic [IDX_W-1:0] i_cur,
  output logic [IDX_W-1:0] o_next,
  output logic             o_any_other
);

  logic [2*N_WAY-1:0] w_dbl;
  logic [N_WAY-1:0]   w_rot;
  logic [IDX_W:0]     w_sum;
  logic               w_found;

  // Bit k of w_rot is the request of approach (i_cur + k) mod N_WAY.
  assign w_dbl       = {i_req_q, i_req_q};
  assign w_rot       = N_WAY'(w_dbl >> i_cur);
  assign o_any_other = |(w_rot >> 1);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    o_next  = (i_cur == IDX_W'(N_WAY - 1)) ? '0 : i_cur + IDX_W'(1);
    for (int unsigned k = 1; k < N_WAY; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_cur} + (IDX_W + 1)'(k);
        o_next  = (w_sum >= (IDX_W + 1)'(N_WAY)) ? IDX_W'(w_sum - (IDX_W + 1)'(N_WAY))
                                                  : IDX_W'(w_sum);
      end
    end
  end

endmodule

// File: rtl/semaforo_multi.sv
// N-approach traffic light controller with latched requests, round-robin service and all-red
// clearance. Optional night flashing mode is enabled by defining NIGHT_FLASH_EN.
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter  int unsigned N_WAY       = 2,
  parameter  int unsigned T_GREEN_MIN = 2,
  parameter  int unsigned T_GREEN_MAX = 8,
  parameter  int unsigned T_YELLOW    = 3,
  parameter  int unsigned T_ALLRED    = 2,
  parameter  int unsigned T_FLASH     = 4,
  localparam int unsigned IDX_W       = $clog2(N_WAY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WAY-1:0]   req,
`ifdef NIGHT_FLASH_EN
  input  logic               night,
`endif
  output logic [3*N_WAY-1:0] lights,
  output logic [1:0]         phase,
  output logic [IDX_W-1:0]   cur_way
);

  localparam int unsigned CNT_MAX = max_of(max_of(max_of(T_GREEN_MAX, T_YELLOW), T_ALLRED),
                                           2 * T_FLASH);
  localparam int unsigned CNT_W   = max_of($clog2(CNT_MAX), 1);

  localparam logic [CNT_W-1:0] CNT_GMIN  = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] CNT_GMAX  = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_YEL   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] CNT_AR    = CNT_W'(T_ALLRED - 1);
`ifdef NIGHT_FLASH_EN
  localparam logic [CNT_W-1:0] CNT_FHALF = CNT_W'(T_FLASH);
  localparam logic [CNT_W-1:0] CNT_FEND  = CNT_W'(2 * T_FLASH - 1);
`endif

  localparam logic [3*N_WAY-1:0] L_RESET = {{(N_WAY - 1){C_RED}}, C_GREEN};

  phase_t             r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_cur_way;
  logic [N_WAY-1:0]   r_req_q;
  logic [3*N_WAY-1:0] r_lights;

  phase_t             w_phase_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_cur_nxt;
  logic [N_WAY-1:0]   w_req_q_nxt;
  logic [N_WAY-1:0]   w_set;
  logic [N_WAY-1:0]   w_clr;
  logic [3*N_WAY-1:0] w_lights_nxt;
  logic [IDX_W-1:0]   w_pick;
  logic               w_any_other;

  semaforo_rr_pick #(
    .N_WAY(N_WAY)
  ) u_pick (
    .i_req_q    (r_req_q),
    .i_cur      (r_cur_way),
    .o_next     (w_pick),
    .o_any_other(w_any_other)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= PH_GREEN;
      r_cnt     <= '0;
      r_cur_way <= '0;
      r_req_q   <= '0;
      r_lights  <= L_RESET;
    end else begin
      r_phase   <= w_phase_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_way <= w_cur_nxt;
      r_req_q   <= w_req_q_nxt;
      r_lights  <= w_lights_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_cur_nxt   = r_cur_way;
    case (r_phase)
      PH_GREEN: begin
        if ((r_cnt == CNT_GMAX) || ((r_cnt >= CNT_GMIN) && w_any_other)) begin
          w_phase_nxt = PH_YELLOW;
          w_cnt_nxt   = '0;
        end
      end
      PH_YELLOW: begin
        if (r_cnt == CNT_YEL) begin
          w_phase_nxt = PH_ALLRED;
          w_cnt_nxt   = '0;
        end
      end
      PH_ALLRED: begin
        if (r_cnt == CNT_AR) begin
          w_phase_nxt = PH_GREEN;
          w_cnt_nxt   = '0;
          w_cur_nxt   = w_pick;
        end
      end
`ifdef NIGHT_FLASH_EN
      PH_FLASH: begin
        if (!night) begin
          w_phase_nxt = PH_ALLRED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_FEND) begin
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_phase_nxt = PH_ALLRED;
        w_cnt_nxt   = '0;
      end
    endcase
`ifdef NIGHT_FLASH_EN
    // Night request preempts any phase; once flashing, the counter keeps its own cadence.
    if (night && (r_phase != PH_FLASH)) begin
      w_phase_nxt = PH_FLASH;
      w_cnt_nxt   = '0;
      w_cur_nxt   = r_cur_way;
    end
`endif
  end

  always_comb begin
    w_set = req;
    if (r_phase == PH_GREEN) w_set[r_cur_way] = 1'b0;
    w_clr = '0;
    if ((w_phase_nxt == PH_GREEN) && (r_phase != PH_GREEN)) w_clr[w_cur_nxt] = 1'b1;
    w_req_q_nxt = (r_req_q | w_set) & ~w_clr;
  end

  // Lamps are decoded from the next state so the registered lights line up with phase.
  always_comb begin
    w_lights_nxt = '0;
    for (int unsigned i = 0; i < N_WAY; i++) begin
      w_lights_nxt[3*i +: 3] = C_RED;
      if (w_cur_nxt == IDX_W'(i)) begin
        if (w_phase_nxt == PH_GREEN)       w_lights_nxt[3*i +: 3] = C_GREEN;
        else if (w_phase_nxt == PH_YELLOW) w_lights_nxt[3*i +: 3] = C_YELLOW;
      end
`ifdef NIGHT_FLASH_EN
      if (w_phase_nxt == PH_FLASH)
        w_lights_nxt[3*i +: 3] = (w_cnt_nxt < CNT_FHALF) ? C_YELLOW : C_DARK;
`endif
    end
  end

  assign lights  = r_lights;
  assign phase   = r_phase;
  assign cur_way = r_cur_way;

endmodule

// File: tb/tb_semaforo_multi.sv
// Scoreboard bench for semaforo_multi: a 2-way and a 4-way instance against expected lamp sequences.
module tb_semaforo_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst4 = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  req4 = '0;
  logic [5:0]  lights;
  logic [1:0]  phase;
  logic [0:0]  cur;
  logic [11:0] lights4;
  logic [1:0]  phase4;
  logic [1:0]  cur4;
`ifdef NIGHT_FLASH_EN
  logic        night = 1'b0;
`endif

  always #5 clk = ~clk;

  semaforo_multi dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
`ifdef NIGHT_FLASH_EN
    .night  (night),
`endif
    .lights (lights),
    .phase  (phase),
    .cur_way(cur)
  );

  semaforo_multi #(
    .N_WAY(4)
  ) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .req    (req4),
`ifdef NIGHT_FLASH_EN
    .night  (1'b0),
`endif
    .lights (lights4),
    .phase  (phase4),
    .cur_way(cur4)
  );

  localparam logic [5:0] G0 = 6'b100_001;
  localparam logic [5:0] Y0 = 6'b100_010;
  localparam logic [5:0] AR = 6'b100_100;
  localparam logic [5:0] G1 = 6'b001_100;
  localparam logic [5:0] Y1 = 6'b010_100;

  typedef struct {
    string       tag;
    logic [11:0] l;
    logic [1:0]  p;
    logic [1:0]  c;
    bit          four;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [11:0] mk4(input int way, input logic [2:0] col);
    logic [11:0] v;
    for (int i = 0; i < 4; i++) v[3*i +: 3] = (i == way) ? col : 3'b100;
    return v;
  endfunction

  task automatic push(input string tag, input logic [11:0] l, input logic [1:0] p,
                      input logic [1:0] c, input bit four);
    exp_t e;
    e.tag = tag; e.l = l; e.p = p; e.c = c; e.four = four;
    sbq.push_back(e);
  endtask

  task automatic push_n(input int n, input string tag, input logic [11:0] l,
                        input logic [1:0] p, input logic [1:0] c, input bit four);
    for (int i = 0; i < n; i++) push(tag, l, p, c, four);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [11:0] al;
    logic [1:0]  ap;
    logic [1:0]  ac;
    n_checks++;
    assert (sbq.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_underflow: observed empty queue, expected pending entry");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.four) begin
        al = lights4; ap = phase4; ac = cur4;
      end else begin
        al = {6'b0, lights}; ap = phase; ac = {1'b0, cur};
      end
      n_checks++;
      assert (al === e.l) else begin
        n_err++;
        $error("FAIL %s lights: observed %b expected %b", e.tag, al, e.l);
      end
      n_checks++;
      assert (ap === e.p) else begin
        n_err++;
        $error("FAIL %s phase: observed %0d expected %0d", e.tag, ap, e.p);
      end
      n_checks++;
      assert (ac === e.c) else begin
        n_err++;
        $error("FAIL %s cur_way: observed %0d expected %0d", e.tag, ac, e.c);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now();
    end
  endtask

  task automatic reset2(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(tag, {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    check_now();
  endtask

  task automatic reset4(input string tag);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    push(tag, mk4(0, 3'b001), 2'd0, 2'd0, 1'b1);
    check_now();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;

    // 1: no requests, full-length phases alternating between the two approaches
    reset2("t1_reset");
    push_n(7, "t1_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(3, "t1_y0", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    push_n(2, "t1_ar0", {6'b0, AR}, 2'd2, 2'd0, 1'b0);
    push_n(8, "t1_g1", {6'b0, G1}, 2'd0, 2'd1, 1'b0);
    push_n(3, "t1_y1", {6'b0, Y1}, 2'd1, 2'd1, 1'b0);
    push_n(2, "t1_ar1", {6'b0, AR}, 2'd2, 2'd1, 1'b0);
    push_n(1, "t1_g0b", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    run(26);

    // 2: one-cycle request for way 1 cuts way 0 green to the minimum
    reset2("t2_reset");
    req = 2'b10;
    push(  "t2_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    run(1);
    req = 2'b00;
    push_n(3, "t2_y0", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    push_n(2, "t2_ar0", {6'b0, AR}, 2'd2, 2'd0, 1'b0);
    push_n(8, "t2_g1", {6'b0, G1}, 2'd0, 2'd1, 1'b0);
    push_n(3, "t2_y1", {6'b0, Y1}, 2'd1, 2'd1, 1'b0);
    push_n(2, "t2_ar1", {6'b0, AR}, 2'd2, 2'd1, 1'b0);
    push_n(8, "t2_g0full", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(1, "t2_y0b", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    run(27);

    // 4: own request ignored during green, latched during yellow
    reset2("t4_reset");
    push_n(7, "t4_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(3, "t4_y0", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    push_n(2, "t4_ar0", {6'b0, AR}, 2'd2, 2'd0, 1'b0);
    push_n(2, "t4_g1cut", {6'b0, G1}, 2'd0, 2'd1, 1'b0);
    push_n(3, "t4_y1", {6'b0, Y1}, 2'd1, 2'd1, 1'b0);
    push_n(2, "t4_ar1", {6'b0, AR}, 2'd2, 2'd1, 1'b0);
    push_n(8, "t4_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(1, "t4_y0b", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    req = 2'b01;
    run(9);
    req = 2'b00;
    run(19);

    // 5: asynchronous reset mid-yellow clears the pending request
    reset2("t5_reset");
    push_n(7, "t5_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(1, "t5_y0", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    run(8);
    req = 2'b10;
    push(  "t5_y0b", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    run(1);
    req = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    push("t5_async", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_n(7, "t5_g0post", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    push_n(1, "t5_y0post", {6'b0, Y0}, 2'd1, 2'd0, 1'b0);
    run(8);

    // 3a: four approaches, no requests -> 0,1,2,3,0
    reset4("t3a_reset");
    for (int w = 0; w < 4; w++) begin
      push_n((w == 0) ? 7 : 8, "t3a_g", mk4(w, 3'b001), 2'd0, 2'(w), 1'b1);
      push_n(3, "t3a_y", mk4(w, 3'b010), 2'd1, 2'(w), 1'b1);
      push_n(2, "t3a_ar", 12'b100_100_100_100, 2'd2, 2'(w), 1'b1);
    end
    push(  "t3a_g0", mk4(0, 3'b001), 2'd0, 2'd0, 1'b1);
    run(52);

    // 3b: request on way 3 skips ways 1 and 2
    reset4("t3b_reset");
    req4 = 4'b1000;
    push(  "t3b_g0", mk4(0, 3'b001), 2'd0, 2'd0, 1'b1);
    run(1);
    req4 = 4'b0000;
    push_n(3, "t3b_y0", mk4(0, 3'b010), 2'd1, 2'd0, 1'b1);
    push_n(2, "t3b_ar0", 12'b100_100_100_100, 2'd2, 2'd0, 1'b1);
    push_n(8, "t3b_g3", mk4(3, 3'b001), 2'd0, 2'd3, 1'b1);
    push_n(3, "t3b_y3", mk4(3, 3'b010), 2'd1, 2'd3, 1'b1);
    push_n(2, "t3b_ar3", 12'b100_100_100_100, 2'd2, 2'd3, 1'b1);
    push(  "t3b_g0b", mk4(0, 3'b001), 2'd0, 2'd0, 1'b1);
    run(19);

`ifdef NIGHT_FLASH_EN
    // 6: night flashing entered mid-green, left through all-red to the next approach
    reset2("t6_reset");
    push_n(3, "t6_g0", {6'b0, G0}, 2'd0, 2'd0, 1'b0);
    run(3);
    night = 1'b1;
    push_n(4, "t6_fy", 12'b0000_0001_0010, 2'd3, 2'd0, 1'b0);
    push_n(4, "t6_dark", 12'b0, 2'd3, 2'd0, 1'b0);
    push_n(2, "t6_fy2", 12'b0000_0001_0010, 2'd3, 2'd0, 1'b0);
    run(10);
    night = 1'b0;
    push_n(2, "t6_ar", {6'b0, AR}, 2'd2, 2'd0, 1'b0);
    push(  "t6_g1", {6'b0, G1}, 2'd0, 2'd1, 1'b0);
    run(3);
`endif

    n_checks++;
    assert (sbq.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
